display_sequencer: RTL and testbench

Sequences the serial digit shifter that drives the 8-digit display. Generates the serial clock and schedules frame refreshes, on a periodic timer and on every keypad `intro` event. For each frame it snapshots the calculator's 32-bit display word, issues a one-sclk-period load strobe, and waits for `tran_done`, with a timeout. It sits between `rpn_stack` (display word, `intro`) and `serial` (load/clock/data, `tran_done`) and replaces free-running divider clocks as the load source.

---
 rtl/calc_pkg.sv | 16 +
 rtl/lz_blank.sv | 24 ++
 rtl/display_sequencer.sv | 133 +++++++++++++
 tb/tb_display_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
// Holds the sequencer state encoding and the display digit geometry.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNAP  = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/lz_blank.sv
// Leading-zero blanker: replaces zero digits above the first nonzero one with BLANK_CODE.
// The least significant digit is always shown, so zero still displays as a single 0.
module lz_blank
    import calc_pkg::*;
(
    input  logic [NUM_DIGITS*DIGIT_W-1:0] raw,
    output logic [NUM_DIGITS*DIGIT_W-1:0] blanked
);

    logic leading;

    always_comb begin
        blanked = raw;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (leading && (raw[i*DIGIT_W +: DIGIT_W] == '0)) begin
                blanked[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Frame scheduler for the serial display shifter: sclk generation, refresh/intro requests, load strobe.
// Define LZ_BLANK_EN to blank leading zero digits of each snapshotted frame.
module display_sequencer
    import calc_pkg::*;
#(
    parameter int SCLK_DIV    = 256,
    parameter int REFRESH_DIV = 8192,
    parameter int TIMEOUT     = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic        intro,
    input  logic        tran_done,
    output logic        sclk,
    output logic        load_data,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        timeout_err
);

    localparam int SCLK_W = $clog2(SCLK_DIV);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int LOAD_W = $clog2(2 * SCLK_DIV);
    localparam int TO_W   = $clog2(TIMEOUT);

    localparam logic [SCLK_W-1:0] SCLK_LAST = SCLK_W'(SCLK_DIV - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(2 * SCLK_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t             state;
    logic [SCLK_W-1:0]  sclk_cnt;
    logic [REF_W-1:0]   ref_cnt;
    logic [LOAD_W-1:0]  load_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               pending;
    logic               refresh_tick;
    logic [31:0]        frame_word;

`ifdef LZ_BLANK_EN
    lz_blank u_lz_blank (
        .raw     (disp_num),
        .blanked (frame_word)
    );
`else
    assign frame_word = disp_num;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_cnt <= '0;
            sclk     <= 1'b0;
        end else if (sclk_cnt == SCLK_LAST) begin
            sclk_cnt <= '0;
            sclk     <= ~sclk;
        end else begin
            sclk_cnt <= sclk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
        end else if (refresh_tick) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    assign refresh_tick = (ref_cnt == REF_LAST);

    // Handshake with the shifter: load_data is a level held for 2*SCLK_DIV clk
    // cycles while data_out is stable; the shifter answers with tran_done (level,
    // sampled only in SHIFT). A request landing on the cycle that enters SNAP is
    // absorbed by that frame, since the snapshot is taken one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 1'b1;
            load_cnt    <= '0;
            to_cnt      <= '0;
            load_data   <= 1'b0;
            data_out    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (refresh_tick || intro) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        state   <= SNAP;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SNAP: begin
                    data_out  <= frame_word;
                    load_data <= 1'b1;
                    load_cnt  <= '0;
                    state     <= LOAD;
                end
                LOAD: begin
                    if (load_cnt == LOAD_LAST) begin
                        load_data <= 1'b0;
                        to_cnt    <= '0;
                        state     <= SHIFT;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (tran_done) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized bench for display_sequencer against a timestamp-based frame model.
// Honours LZ_BLANK_EN the same way as the design.
module tb_display_sequencer;

    localparam int SCLK_DIV    = 4;
    localparam int REFRESH_DIV = 200;
    localparam int TIMEOUT     = 100;
    localparam int LOAD_LEN    = 2 * SCLK_DIV;
    localparam int RUN_CYCLES  = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] disp_num = '0;
    logic        intro = 1'b0;
    logic        tran_done = 1'b0;
    logic        sclk;
    logic        load_data;
    logic [31:0] data_out;
    logic        busy;
    logic        timeout_err;

    display_sequencer #(
        .SCLK_DIV    (SCLK_DIV),
        .REFRESH_DIV (REFRESH_DIV),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_num    (disp_num),
        .intro       (intro),
        .tran_done   (tran_done),
        .sclk        (sclk),
        .load_data   (load_data),
        .data_out    (data_out),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: edge count since reset release, pending request, and the current
    // frame as timestamps (f = edge entering SNAP, ss = edge entering SHIFT)
    int          n;
    bit          m_pend;
    bit          m_active;
    int          f;
    int          ss;
    bit          m_err;
    logic [31:0] m_data;
    int          td_edge;
    int          resets_done;
    int          frames;
    int          timeouts;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [31:0] model_frame(input logic [31:0] v);
        logic [31:0] r;
        r = v;
`ifdef LZ_BLANK_EN
        for (int d = 7; d >= 1; d--) begin
            if (v[d*4 +: 4] != 4'h0) break;
            r[d*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] pick_disp();
        logic [31:0] v;
        int k;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0120;
            1: v = 32'h0000_0000;
            default: begin
                v = $urandom;
                k = $urandom_range(0, 8);
                if (k > 0) v = v & (32'hFFFF_FFFF >> (4 * k));
            end
        endcase
        return v;
    endfunction

    task automatic model_reset();
        n        = 0;
        m_pend   = 1'b1;
        m_active = 1'b0;
        f        = -1000;
        ss       = -1000;
        m_err    = 1'b0;
        m_data   = '0;
        td_edge  = -1;
        exp_q.delete();
    endtask

    // one rising edge as seen by the model, using the inputs present at that edge
    task automatic model_edge();
        bit req;
        bit start_now;
        n++;
        req = intro || ((n % REFRESH_DIV) == 0);
        start_now = 1'b0;
        if (!m_active && m_pend) begin
            start_now = 1'b1;
            m_active  = 1'b1;
            f         = n;
            ss        = n + 1 + LOAD_LEN;
            td_edge   = ss + $urandom_range(0, 130);
            frames++;
        end else if (m_active && n > ss) begin
            if (tran_done) begin
                m_active = 1'b0;
                m_err    = 1'b0;
            end else if (n == ss + TIMEOUT) begin
                m_active = 1'b0;
                m_err    = 1'b1;
                timeouts++;
            end
        end
        if (m_active && n == f + 1) begin
            m_data = model_frame(disp_num);
            exp_q.push_back(m_data);
        end
        if (start_now) m_pend = 1'b0;
        else if (req)  m_pend = 1'b1;
    endtask

    task automatic check_outputs();
        logic exp_load;
        exp_load = m_active && (n >= f + 1) && (n <= f + LOAD_LEN);
        check_val("sclk", 32'(sclk), 32'((n / SCLK_DIV) % 2));
        check_val("busy", 32'(busy), 32'(m_active));
        check_val("load_data", 32'(load_data), 32'(exp_load));
        check_val("data_out", data_out, m_data);
        check_val("timeout_err", 32'(timeout_err), 32'(m_err));
        if (m_active && n == f + 1) begin
            if (exp_q.size() == 0) begin
                check_val("frame_queue_empty", 32'd1, 32'd0);
            end else begin
                check_val("frame_word", data_out, exp_q.pop_front());
            end
        end
    endtask

    // driver: stimulus for the edge after this negedge
    task automatic drive_inputs();
        intro     = ($urandom_range(0, 39) == 0);
        tran_done = ((n + 1) == td_edge);
        if ($urandom_range(0, 3) == 0) disp_num = pick_disp();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_sclk"}, 32'(sclk), 32'd0);
        check_val({tag, "_load_data"}, 32'(load_data), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_data_out"}, data_out, 32'd0);
        check_val({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        resets_done = 0;
        frames      = 0;
        timeouts    = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        disp_num = pick_disp();
        rst = 1'b0;
        for (int cyc = 0; cyc < RUN_CYCLES; cyc++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
            if (m_active && n >= f + 2 && n < f + LOAD_LEN &&
                resets_done < 4 &&
                ($urandom_range(0, 5) == 0 || (resets_done == 0 && cyc > 1500))) begin
                // asynchronous reset in the middle of a load strobe
                intro     = 1'b0;
                tran_done = 1'b0;
                #2 rst = 1'b1;
                #1 check_reset_values("async_reset");
                resets_done++;
                @(negedge clk);
                @(negedge clk);
                model_reset();
                disp_num = pick_disp();
                rst = 1'b0;
            end else begin
                drive_inputs();
            end
        end
        check_val("frames_seen", 32'(frames > 10), 32'd1);
        check_val("resets_seen", 32'(resets_done > 0), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
